// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the iterative mul/div sequencer.
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, rs1_data, rs2_data, flush,
                  input  busy, stall, done, result);
  modport slave  (input  start, op, rs1_data, rs2_data, flush,
                  output busy, stall, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit; one iteration per cycle, XLEN iterations.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN:0]   div_sh;
  logic [XLEN:0]     div_diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // acc holds {partial product high, multiplier} for mul and {remainder, dividend/quotient} for div.
  // The remainder never reaches the divisor, so XLEN bits suffice between iterations.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q, 1'b0};
    div_diff = div_sh[2*XLEN:XLEN] - {1'b0, b_q};

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d  = bus.op;
          cnt_d = '0;
          b_d   = bus.op[1] ? bus.rs2_data : bus.rs1_data;
          acc_d = {{XLEN{1'b0}}, (bus.op[1] ? bus.rs1_data : bus.rs2_data)};
          if (bus.op[1] && (bus.rs2_data == '0)) begin
            state_d  = DONE;
            result_d = bus.op[0] ? bus.rs1_data : '1;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
          else                 acc_d = div_sh[2*XLEN-1:0];
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d  = DONE;
          // op[0] selects the high half for both MULHU (high product) and REMU (remainder).
          result_d = op_q[0] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.stall  = ((state_q == IDLE) && bus.start && !bus.flush) || (state_q == RUN);
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed test of muldiv_seq with a result scoreboard popped on every done pulse.
module tb_muldiv_seq;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [XLEN-1:0] sb_q[$];
  logic [XLEN-1:0] last_res;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();
  muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%08h with no op outstanding", bus.result);
      end else begin
        logic [XLEN-1:0] e;
        e = sb_q.pop_front();
        if (bus.result !== e) begin
          n_fail++;
          $display("FAIL result: got 0x%08h expected 0x%08h", bus.result, e);
        end
      end
    end
  end

  // Drive one start on the edge E0; returns #1 after E0 with start low.
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input bit push);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b;
    #1 chk("stall_on_start", {31'b0, bus.stall}, 32'd1);
    if (push) sb_q.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.rs1_data = ~a; bus.rs2_data = ~b; bus.op = ~op;
  endtask

  // Count cycles from E0 until done, and busy cycles seen on the way.
  task automatic wait_done(input string name, input int exp_cyc, input int exp_busy);
    int cyc = 0;
    int nbusy = 0;
    bit seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) seen = 1;
      else if (bus.busy === 1'b1) nbusy++;
    end
    chk({name, "_latency"}, cyc, exp_cyc);
    chk({name, "_busy_cycles"}, nbusy, exp_busy);
    chk({name, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    chk({name, "_stall_at_done"}, {31'b0, bus.stall}, 32'd0);
    last_res = bus.result;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.rs1_data = '0; bus.rs2_data = '0; bus.flush = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy",   {31'b0, bus.busy},  32'd0);
    chk("reset_done",   {31'b0, bus.done},  32'd0);
    chk("reset_stall",  {31'b0, bus.stall}, 32'd0);
    chk("reset_result", bus.result, 32'd0);

    issue(2'b00, 32'd7, 32'd6, 32'd42, 1);                         wait_done("mul_7x6", 33, 32);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);  wait_done("mulhu_max", 33, 32);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);  wait_done("mul_max", 33, 32);
    issue(2'b10, 32'd100, 32'd7, 32'd14, 1);                       wait_done("divu_100_7", 33, 32);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 1);                        wait_done("remu_100_7", 33, 32);
    issue(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1);          wait_done("divu_bigdiv", 33, 32);
    issue(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1);  wait_done("remu_bigdiv", 33, 32);
    issue(2'b11, 32'h1234_5678, 32'h0000_0100, 32'h0000_0078, 1);  wait_done("remu_256", 33, 32);
    issue(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);                  wait_done("divu_by0", 1, 0);
    issue(2'b11, 32'd5, 32'd0, 32'd5, 1);                          wait_done("remu_by0", 1, 0);

    // Flush at iteration 10: back to IDLE, no done, result untouched.
    issue(2'b00, 32'd3, 32'd4, 32'd12, 0);
    repeat (10) @(posedge clk);
    @(negedge clk) bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("flush_busy", {31'b0, bus.busy}, 32'd0);
    chk("flush_result_kept", bus.result, last_res);
    repeat (40) @(negedge clk);
    chk("flush_result_still", bus.result, last_res);
    issue(2'b00, 32'd3, 32'd4, 32'd12, 1);                         wait_done("mul_3x4", 33, 32);

    // A second start during RUN must not disturb the running op.
    issue(2'b00, 32'd9, 32'd11, 32'd99, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.rs1_data = 32'd50; bus.rs2_data = 32'd5;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("start_while_busy", 27, 26);

    // Reset at iteration 20 clears everything; next op runs normally.
    issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 0);
    repeat (20) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_mid_busy",   {31'b0, bus.busy}, 32'd0);
    chk("rst_mid_done",   {31'b0, bus.done}, 32'd0);
    chk("rst_mid_result", bus.result, 32'd0);
    issue(2'b10, 32'd1000, 32'd10, 32'd100, 1);                    wait_done("divu_after_rst", 33, 32);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
